// File: rtl/led_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_shift_ctrl
//  Purpose  : Push-button driven LED pattern shifter with wrap/zero-fill
//             shifting, runtime pattern reload and an idle-timeout blanker.
//  Revision : 1.0  initial release
// ============================================================================
module led_shift_ctrl #(
  parameter int                N_LEDS         = 10,
  parameter int                TIMEOUT_CYCLES = 20,
  parameter logic [N_LEDS-1:0] INIT_PATTERN   = {1'b1, {(N_LEDS-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active low
  input  logic              shift_right,
  input  logic              shift_left,
  input  logic              Reconfigure,
  input  logic [N_LEDS-1:0] cfg_pattern,
  input  logic              wrap_en,
  output logic [N_LEDS-1:0] LED,
  output logic              LED_timeout,
  output logic              empty
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [0:0] c_ST_ACTIVE  = 1'b0;
  localparam logic [0:0] c_ST_TIMEOUT = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [N_LEDS-1:0] r_pattern;
  logic [N_LEDS-1:0] w_pattern_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  logic r_prev_right;
  logic r_prev_left;
  logic r_prev_cfg;

  logic w_edge_right;
  logic w_edge_left;
  logic w_edge_cfg;
  logic w_event;

  // Rising-edge detection on the already-synchronised button levels
  assign w_edge_right = shift_right & ~r_prev_right;
  assign w_edge_left  = shift_left  & ~r_prev_left;
  assign w_edge_cfg   = Reconfigure & ~r_prev_cfg;
  assign w_event      = w_edge_cfg | w_edge_right | w_edge_left;

  // Previous-value registers; reset high so a button held through reset
  // release does not look like a fresh press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_right <= 1'b1;
      r_prev_left  <= 1'b1;
      r_prev_cfg   <= 1'b1;
    end else begin
      r_prev_right <= shift_right;
      r_prev_left  <= shift_left;
      r_prev_cfg   <= Reconfigure;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_ACTIVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: idle expiry enters TIMEOUT, only a reload leaves it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_ACTIVE: begin
        if (!w_event && (r_cnt == c_CNT_LAST)) begin
          w_state_nxt = c_ST_TIMEOUT;
        end
      end
      c_ST_TIMEOUT: begin
        if (w_edge_cfg) begin
          w_state_nxt = c_ST_ACTIVE;
        end
      end
      default: w_state_nxt = c_ST_ACTIVE;
    endcase
  end

  // Pattern and idle-counter update: reload beats shifts, opposing shifts
  // cancel but still count as activity; the counter freezes in TIMEOUT
  always_comb begin
    w_pattern_nxt = r_pattern;
    w_cnt_nxt     = r_cnt;
    if (r_state == c_ST_ACTIVE) begin
      if (w_event) begin
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + c_CNT_ONE;
      end
      if (w_edge_cfg) begin
        w_pattern_nxt = cfg_pattern;
      end else if (w_edge_right && !w_edge_left) begin
        w_pattern_nxt = {(wrap_en ? r_pattern[0] : 1'b0), r_pattern[N_LEDS-1:1]};
      end else if (w_edge_left && !w_edge_right) begin
        w_pattern_nxt = {r_pattern[N_LEDS-2:0], (wrap_en ? r_pattern[N_LEDS-1] : 1'b0)};
      end
    end else if (w_edge_cfg) begin
      w_pattern_nxt = cfg_pattern;
      w_cnt_nxt     = '0;
    end
  end

  // Pattern and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= INIT_PATTERN;
      r_cnt     <= '0;
    end else begin
      r_pattern <= w_pattern_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Outputs decoded from registered state and pattern only
  always_comb begin
    LED         = r_pattern;
    LED_timeout = 1'b0;
    if (r_state == c_ST_TIMEOUT) begin
      LED         = '0;
      LED_timeout = 1'b1;
    end
    empty = ~|r_pattern;
  end

endmodule
`default_nettype wire

// File: tb/tb_led_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_shift_ctrl
//  Purpose  : Directed self-checking bench for led_shift_ctrl (N_LEDS=10,
//             TIMEOUT_CYCLES=20).
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift_right;
  logic       shift_left;
  logic       Reconfigure;
  logic [9:0] cfg_pattern;
  logic       wrap_en;
  logic [9:0] LED;
  logic       LED_timeout;
  logic       empty;

  int checks = 0;
  int errors = 0;

  led_shift_ctrl #(
    .N_LEDS         (10),
    .TIMEOUT_CYCLES (20),
    .INIT_PATTERN   (10'b1000000000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .shift_right (shift_right),
    .shift_left  (shift_left),
    .Reconfigure (Reconfigure),
    .cfg_pattern (cfg_pattern),
    .wrap_en     (wrap_en),
    .LED         (LED),
    .LED_timeout (LED_timeout),
    .empty       (empty)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; shift_right = 1'b0; shift_left = 1'b0; Reconfigure = 1'b0;
    cfg_pattern = 10'b0; wrap_en = 1'b0;
    tick(2);
    chk("rst_led",   LED, 10'b1000000000);
    chk("rst_to",    {9'b0, LED_timeout}, 10'd0);
    chk("rst_empty", {9'b0, empty}, 10'd0);
    rst = 1'b1;
    tick(1);

    // Single right shift
    shift_right = 1'b1; tick(1);
    chk("t1_led", LED, 10'b0100000000);
    chk("t1_to",  {9'b0, LED_timeout}, 10'd0);
    shift_right = 1'b0; tick(1);

    // Wrap vs zero-fill right shift
    Reconfigure = 1'b1; cfg_pattern = 10'b0000000001; tick(1);
    chk("t2_load", LED, 10'b0000000001);
    Reconfigure = 1'b0; wrap_en = 1'b1; shift_right = 1'b1; tick(1);
    chk("t2_wrap", LED, 10'b1000000000);
    shift_right = 1'b0; Reconfigure = 1'b1; tick(1);
    chk("t2_reload", LED, 10'b0000000001);
    Reconfigure = 1'b0; wrap_en = 1'b0; shift_right = 1'b1; tick(1);
    chk("t2_nowrap", LED, 10'b0000000000);
    chk("t2_empty",  {9'b0, empty}, 10'd1);
    shift_right = 1'b0; tick(1);
    shift_right = 1'b1; tick(1);
    chk("t2_zero_stay", LED, 10'b0000000000);
    shift_right = 1'b0; wrap_en = 1'b1; shift_left = 1'b1; tick(1);
    chk("t2_wrap_zero", LED, 10'b0000000000);
    shift_left = 1'b0; tick(1);

    // Held button gives one shift only
    Reconfigure = 1'b1; cfg_pattern = 10'b0000000011; wrap_en = 1'b0; tick(1);
    Reconfigure = 1'b0;
    shift_left = 1'b1; tick(1);
    chk("t3_first", LED, 10'b0000000110);
    tick(4);
    chk("t3_held", LED, 10'b0000000110);
    shift_left = 1'b0; tick(1);
    shift_left = 1'b1; tick(1);
    chk("t3_second", LED, 10'b0000001100);
    shift_left = 1'b0;
    Reconfigure = 1'b1; cfg_pattern = 10'b1000000001; tick(1);
    Reconfigure = 1'b0; wrap_en = 1'b1; shift_left = 1'b1; tick(1);
    chk("t3_wrap_left", LED, 10'b0000000011);
    shift_left = 1'b0;

    // Idle timeout 20 edges after the last event
    tick(19);
    chk("t4_pre_to",  {9'b0, LED_timeout}, 10'd0);
    chk("t4_pre_led", LED, 10'b0000000011);
    tick(1);
    chk("t4_to",      {9'b0, LED_timeout}, 10'd1);
    chk("t4_blank",   LED, 10'b0000000000);
    chk("t4_held",    {9'b0, empty}, 10'd0);
    shift_right = 1'b1; tick(1);
    chk("t4_ign_led", LED, 10'b0000000000);
    chk("t4_ign_to",  {9'b0, LED_timeout}, 10'd1);
    shift_right = 1'b0; tick(1);

    // Reload exits timeout and re-arms it
    Reconfigure = 1'b1; cfg_pattern = 10'b1010101010; tick(1);
    chk("t5_led", LED, 10'b1010101010);
    chk("t5_to",  {9'b0, LED_timeout}, 10'd0);
    Reconfigure = 1'b0;
    tick(19);
    chk("t5_pre_to", {9'b0, LED_timeout}, 10'd0);
    tick(1);
    chk("t5_rearm", {9'b0, LED_timeout}, 10'd1);
    Reconfigure = 1'b1; cfg_pattern = 10'b1100000000; tick(1);
    chk("t5_exit2", LED, 10'b1100000000);
    Reconfigure = 1'b0;

    // Both shift edges together: no shift, counter cleared
    tick(10);
    shift_left = 1'b1; shift_right = 1'b1; tick(1);
    chk("t6_both", LED, 10'b1100000000);
    shift_left = 1'b0; shift_right = 1'b0;
    tick(19);
    chk("t6_both_to0", {9'b0, LED_timeout}, 10'd0);
    tick(1);
    chk("t6_both_to1", {9'b0, LED_timeout}, 10'd1);
    Reconfigure = 1'b1; tick(1);
    Reconfigure = 1'b0; tick(1);

    // Reload wins over a simultaneous shift
    Reconfigure = 1'b1; shift_right = 1'b1; cfg_pattern = 10'b0000011111; tick(1);
    chk("t6_cfg_wins", LED, 10'b0000011111);
    Reconfigure = 1'b0; shift_right = 1'b0; tick(1);

    // Asynchronous reset mid-shift
    shift_right = 1'b1; rst = 1'b0; #1;
    chk("t6_rst_async", LED, 10'b1000000000);
    tick(1);
    chk("t6_rst_hold", LED, 10'b1000000000);
    rst = 1'b1; tick(1);
    chk("t6_no_edge", LED, 10'b1000000000);
    shift_right = 1'b0; tick(1);
    shift_right = 1'b1; tick(1);
    chk("t6_after_rst", LED, 10'b0100000000);
    shift_right = 1'b0; tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
